// File: rtl/spart_rx.sv
// spart_rx: SPART receive datapath. Deserialises an 8N1 line using the
// 16x oversampling enable from the baud generator and holds the last byte
// for the bus interface.
//
// Ports:
//   clk      system clock
//   rst      asynchronous active-low reset
//   enable   one-clk pulse at 16x baud; all bit timing advances on it
//   rxd      asynchronous serial input, idle high
//   rd_ack   one-clk read strobe from the bus interface (clears rda/ovr)
//   rx_data  holding register, last received byte
//   rda      receive data available
//   ferr     stop bit of the byte in rx_data was sampled low
//   ovr      a new byte overwrote an unread one
module spart_rx (
  input  logic       clk,
  input  logic       rst,
  input  logic       enable,
  input  logic       rxd,
  input  logic       rd_ack,
  output logic [7:0] rx_data,
  output logic       rda,
  output logic       ferr,
  output logic       ovr
);

  typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_t;

  state_t     state, state_nxt;
  logic       rxd_m, rxd_s;
  logic [3:0] cnt;
  logic [2:0] bcnt;
  logic [7:0] sh;

  // control strobes decoded from the FSM
  logic cnt_clr, cnt_inc, bcnt_clr, bit_smp, load;

  // two-flop synchroniser; idles high so reset does not look like a start bit
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      rxd_m <= 1'b1;
      rxd_s <= 1'b1;
    end else begin
      rxd_m <= rxd;
      rxd_s <= rxd_m;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state <= IDLE;
    else      state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    if (enable) begin
      case (state)
        IDLE:  if (!rxd_s) state_nxt = START;
        // mid-start-bit check rejects glitches shorter than half a bit
        START: if (cnt == 4'd7) state_nxt = rxd_s ? IDLE : DATA;
        DATA:  if (cnt == 4'd15 && bcnt == 3'd7) state_nxt = STOP;
        STOP:  if (cnt == 4'd15) state_nxt = IDLE;
        default: state_nxt = IDLE;
      endcase
    end
  end

  always_comb begin
    cnt_clr  = 1'b0;
    cnt_inc  = 1'b0;
    bcnt_clr = 1'b0;
    bit_smp  = 1'b0;
    load     = 1'b0;
    if (enable) begin
      case (state)
        IDLE: cnt_clr = !rxd_s;
        START: begin
          if (cnt == 4'd7) begin
            cnt_clr  = 1'b1;
            bcnt_clr = 1'b1;
          end else begin
            cnt_inc = 1'b1;
          end
        end
        // cnt wraps 15 -> 0 on its own, so the centre sample needs no clear
        DATA: begin
          cnt_inc = 1'b1;
          bit_smp = (cnt == 4'd15);
        end
        STOP: begin
          cnt_inc = 1'b1;
          load    = (cnt == 4'd15);
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      cnt  <= 4'd0;
      bcnt <= 3'd0;
      sh   <= 8'h00;
    end else begin
      if (cnt_clr)      cnt <= 4'd0;
      else if (cnt_inc) cnt <= cnt + 4'd1;
      if (bcnt_clr)     bcnt <= 3'd0;
      else if (bit_smp) bcnt <= bcnt + 3'd1;
      if (bit_smp)      sh <= {rxd_s, sh[7:1]};
    end
  end

  // a load coinciding with rd_ack wins: the ack refers to the old byte,
  // so the new one stays available and is not an overrun
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      rx_data <= 8'h00;
      rda     <= 1'b0;
      ferr    <= 1'b0;
      ovr     <= 1'b0;
    end else if (load) begin
      rx_data <= sh;
      rda     <= 1'b1;
      ferr    <= ~rxd_s;
      ovr     <= rda & ~rd_ack;
    end else if (rd_ack) begin
      rda <= 1'b0;
      ovr <= 1'b0;
    end
  end

endmodule

// File: tb/tb_spart_rx.sv
// Bench for spart_rx: frames are built bit-by-bit from the byte value and
// driven on enable ticks (one tick every 4 clk). A frame-level model tracks
// the expected holding register and flags; expectations are queued with the
// cycle they become visible and a monitor compares on the falling edge.
module tb_spart_rx;

  logic       clk = 1'b0;
  logic       rst, enable, rxd, rd_ack;
  logic [7:0] rx_data;
  logic       rda, ferr, ovr;

  int cyc = 0;
  int n_vec = 0;
  int n_err = 0;

  typedef struct {
    int         due;
    logic [7:0] data;
    logic       rda;
    logic       ferr;
    logic       ovr;
    string      name;
  } exp_t;

  exp_t sbq[$];
  exp_t e_mon;

  // frame-level reference state
  logic [7:0] m_data;
  logic       m_unread, m_ferr, m_ovr;

  spart_rx dut (
    .clk(clk), .rst(rst), .enable(enable), .rxd(rxd), .rd_ack(rd_ack),
    .rx_data(rx_data), .rda(rda), .ferr(ferr), .ovr(ovr)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin
    while (sbq.size() > 0 && sbq[0].due <= cyc) begin
      e_mon = sbq.pop_front();
      n_vec++;
      if (e_mon.due != cyc || rx_data !== e_mon.data || rda !== e_mon.rda ||
          ferr !== e_mon.ferr || ovr !== e_mon.ovr) begin
        n_err++;
        $display("FAIL %s @%0d: got data=%h rda=%b ferr=%b ovr=%b, want data=%h rda=%b ferr=%b ovr=%b (due %0d)",
                 e_mon.name, cyc, rx_data, rda, ferr, ovr,
                 e_mon.data, e_mon.rda, e_mon.ferr, e_mon.ovr, e_mon.due);
      end
    end
  end

  initial begin
    #600000;
    $display("FAIL watchdog: simulation still running at cycle %0d, required to finish", cyc);
    $fatal(1, "watchdog");
  end

  task automatic push(input string nm);
    sbq.push_back('{cyc, m_data, m_unread, m_ferr, m_ovr, nm});
  endtask

  // one enable pulse; rxd set before the call is visible to this tick
  task automatic tick(input logic ack);
    repeat (3) @(posedge clk);
    #1 enable = 1'b1; rd_ack = ack;
    @(posedge clk);
    #1 enable = 1'b0; rd_ack = 1'b0;
  endtask

  task automatic read_ack(input string nm);
    @(posedge clk);
    #1 rd_ack = 1'b1;
    @(posedge clk);
    #1 rd_ack = 1'b0;
    m_unread = 1'b0;
    m_ovr    = 1'b0;
    push(nm);
  endtask

  // ticks 0..15 start, 16..143 data LSB first, 144..152 stop; the stop is
  // sampled on tick 152 and the line returns high right after
  task automatic send_frame(input logic [7:0] b, input logic stop,
                            input logic ack_at_load, input int gap_at,
                            input string nm);
    logic [7:0] bv;
    bv = b;
    for (int t = 0; t < 153; t++) begin
      if (t < 16)       rxd = 1'b0;
      else if (t < 144) rxd = bv[3'((t - 16) / 16)];
      else              rxd = stop;
      if (t == gap_at) begin
        if (m_unread) read_ack("gap_read");
        repeat (100) @(posedge clk);
        #1;
      end
      tick((t == 152) ? ack_at_load : 1'b0);
    end
    m_ovr    = m_unread && !ack_at_load;
    m_unread = 1'b1;
    m_data   = b;
    m_ferr   = !stop;
    push(nm);
    rxd = 1'b1;
    repeat (12) tick(1'b0);
  endtask

  initial begin
    logic [7:0] rb;
    logic       rs, ra;
    logic [7:0] pb;
    rst = 1'b0; enable = 1'b0; rxd = 1'b1; rd_ack = 1'b0;
    m_data = 8'h00; m_unread = 1'b0; m_ferr = 1'b0; m_ovr = 1'b0;
    @(posedge clk); #1;
    push("reset");
    repeat (2) @(posedge clk);
    #1 rst = 1'b1;
    repeat (4) tick(1'b0);

    send_frame(8'hA5, 1'b1, 1'b0, -1, "nominal_a5");
    read_ack("read_a5");

    // start glitch of 3 ticks must be rejected at mid-bit
    rxd = 1'b0;
    repeat (3) tick(1'b0);
    rxd = 1'b1;
    repeat (10) tick(1'b0);
    push("glitch");
    send_frame(8'h3C, 1'b1, 1'b0, -1, "after_glitch_3c");
    read_ack("read_3c");

    send_frame(8'h81, 1'b0, 1'b0, -1, "ferr_81");
    send_frame(8'h55, 1'b1, 1'b0, -1, "ferr_clear_55");
    read_ack("read_55");

    send_frame(8'h11, 1'b1, 1'b0, -1, "ovr_first_11");
    send_frame(8'h22, 1'b1, 1'b0, -1, "ovr_22");
    read_ack("read_ovr");

    send_frame(8'h99, 1'b1, 1'b0, -1, "pre_sim_99");
    send_frame(8'h7E, 1'b1, 1'b1, -1, "sim_load_7e");

    // reset in the middle of data bit 4
    pb = 8'hF0;
    for (int t = 0; t < 88; t++) begin
      rxd = (t < 16) ? 1'b0 : pb[3'((t - 16) / 16)];
      tick(1'b0);
    end
    @(posedge clk);
    #1 rst = 1'b0;
    m_data = 8'h00; m_unread = 1'b0; m_ferr = 1'b0; m_ovr = 1'b0;
    push("rst_mid");
    repeat (2) @(posedge clk);
    #1 rxd = 1'b1; rst = 1'b1;
    repeat (4) tick(1'b0);
    send_frame(8'hC3, 1'b1, 1'b0, -1, "after_rst_c3");

    // enable held low for 100 clk mid-frame, with a read serviced inside
    send_frame(8'h0F, 1'b1, 1'b0, 70, "gated_0f");
    read_ack("read_0f");

    for (int k = 0; k < 8; k++) begin
      rb = 8'($urandom);
      rs = ($urandom_range(0, 3) != 0);
      ra = ($urandom_range(0, 3) == 0);
      send_frame(rb, rs, ra, -1, "random");
      if ($urandom_range(0, 1) == 1) read_ack("random_read");
    end

    repeat (4) @(posedge clk);
    if (sbq.size() != 0) begin
      n_err++;
      $display("FAIL drain: got %0d pending checks, want 0", sbq.size());
    end
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/spart_rx.md
# spart_rx

Receive datapath of the SPART, the stage that produces the `rda` flag and the received byte read by the echo driver.
- Deserialises an asynchronous 8N1 serial line using the 16x oversampling tick from the SPART baud generator.
- Validates the start bit at mid-bit and samples each data and stop bit at its centre.
- Presents the byte in a holding register, with data-available, framing-error and overrun flags, to the SPART bus interface.

## Interface
- No parameters. 16x oversampling, 8 data bits, no parity and 1 stop bit are fixed.
- `clk`  in  1  system clock (100 MHz).
- `rst`  in  1  asynchronous, active-low reset.
- `enable`  in  1  one-`clk` pulse at 16x the baud rate, from the baud generator. All bit timing advances only on cycles where `enable`=1.
- `rxd`  in  1  asynchronous serial input, idle high.
- `rd_ack`  in  1  one-`clk` pulse from the bus interface on a read of IOADDR 00 (`iocs`=1, `iorw`=1).
- `rx_data`  out  8  last received byte (holding register).
- `rda`  out  1  receive data available.
- `ferr`  out  1  framing error: stop bit of the byte in `rx_data` sampled low.
- `ovr`  out  1  overrun: a new byte overwrote an unread one.

## Operation
- **Synchroniser:** `rxd` passes through 2 flops (reset value 1) to form `rxd_s`. All logic uses only `rxd_s`.
- **Counters:** 4-bit sample counter `cnt`; 3-bit bit counter `bcnt`; 8-bit shift register `sh`.
- **IDLE:** on `enable` with `rxd_s`=0 → START, `cnt`=0.
- **START:** on each `enable`, `cnt`++.
  - When `cnt`==7 at an `enable`: if `rxd_s`=0 → DATA with `cnt`=0, `bcnt`=0.
  - Otherwise (false start or glitch) → IDLE, with no flag change.
- **DATA:** on each `enable`, `cnt`++.
  - When `cnt`==15 at an `enable`: `sh` <= {`rxd_s`, `sh[7:1]`} (LSB first), `cnt`=0, `bcnt`++.
  - After the sample with `bcnt`==7 → STOP.
- **STOP:** on each `enable`, `cnt`++. When `cnt`==15 at an `enable`:
  - `rx_data` <= `sh`, `rda` <= 1, `ferr` <= ~`rxd_s`.
  - `ovr` <= 1 if `rda` was 1 and `rd_ack`=0 this cycle; otherwise `ovr` <= 0.
  - → IDLE.
- **After a framing error:** if `rxd_s` is still low in IDLE, the next `enable` starts a new frame. This is the required behaviour, not a fault.
- **`rd_ack`:** clears `rda` and `ovr` on the next edge. `ferr` and `rx_data` hold until the next load.
- **Simultaneous load and `rd_ack`:** the load wins. `rda` stays 1, the new byte is in `rx_data`, and `ovr`=0.
- **`rd_ack` with `rda`=0:** no effect.
- **`enable` low:** the FSM, counters and shift register hold indefinitely. `rd_ack` is still serviced.

## Timing
- **Reset values (asynchronous, while `rst`=0):**
  - state IDLE; `cnt`, `bcnt`, `sh` = 0.
  - `rx_data`=8'h00, `rda`=0, `ferr`=0, `ovr`=0.
  - synchroniser flops = 1.
- **Reset mid-frame:** the partial frame is discarded. Reception resumes from IDLE on the first low `rxd_s` after release.
- **Input latency:** 2 `clk` from an `rxd` change to `rxd_s`.
- **Frame timing in `enable` ticks:** let T0 be the tick on which IDLE sees `rxd_s`=0.
  - Start validated at T8.
  - Data bit n sampled at T24+16n (bit 7 at T136).
  - Stop sampled at T152.
- **Flag timing:** `rda`, `ferr`, `ovr` and `rx_data` update on the `clk` edge of T152 and are visible the following cycle.
- **Read clear:** `rda` falls on the first edge after `rd_ack` (1-cycle latency).
- **Outputs:** all are registered; no combinational path from input to output.

## Test plan
- **Nominal byte:** `enable` every 4 `clk`; send 0xA5 (LSB first, stop=1) → `rx_data`=8'hA5, `rda`=1, `ferr`=0, `ovr`=0 at tick T152. Then `rd_ack` → `rda`=0 next cycle, `rx_data` still A5.
- **Start glitch:** `rxd` low for 3 ticks, then high → no `rda`, FSM back in IDLE. A following 0x3C is received correctly.
- **Framing error:** send 0x81 with stop bit 0 → `rda`=1, `ferr`=1, `rx_data`=8'h81. Next valid 0x55 → `ferr`=0.
- **Overrun:** send 0x11 then 0x22 with no `rd_ack` → `rx_data`=8'h22, `rda`=1, `ovr`=1. `rd_ack` → `rda`=0, `ovr`=0.
- **Simultaneous load and read:** `rd_ack` pulsed on the same `clk` as the T152 load of 0x7E while `rda`=1 → `rda`=1, `ovr`=0, `rx_data`=8'h7E.
- **Reset and enable gating:** assert `rst` low at bit 4 of a frame → all outputs 0 immediately; after release, 0xC3 is received correctly. Also hold `enable` low for 100 `clk` mid-frame → byte 0x0F still received correctly.
